// File: rtl/counter_disable_delay_if.sv
// counter_disable_delay_if: control/status bundle for counter_disable_delay.
// Ports (via modports): enable, delay, force_stop driven by master;
// delayedEnable, stopping, stop_done driven by slave (the delay block).
// Purpose: groups the request inputs and registered status outputs.
// Latency: none, wires only.
// Backpressure: none, level-based request interface.
interface counter_disable_delay_if #(
   parameter int COUNTER_WIDTH = 16
);
   logic                     enable;
   logic [COUNTER_WIDTH-1:0] delay;
   logic                     force_stop;
   logic                     delayedEnable;
   logic                     stopping;
   logic                     stop_done;

   modport master (
      output enable,
      output delay,
      output force_stop,
      input  delayedEnable,
      input  stopping,
      input  stop_done
   );

   modport slave (
      input  enable,
      input  delay,
      input  force_stop,
      output delayedEnable,
      output stopping,
      output stop_done
   );
endinterface

// File: rtl/counter_disable_delay.sv
// counter_disable_delay: passes enable through immediately on turn-on and
// holds it for a programmable number of cycles on turn-off.
// Ports: clock, reset (async active-low), bus (slave modport) carrying
// enable/delay/force_stop in and delayedEnable/stopping/stop_done out.
// Purpose: delayed-off enable with abort (force_stop) and re-assert cancel.
// Latency: 1 cycle registered turn-on; turn-off after `delay` cycles.
// Backpressure: none; enable is a level request, force_stop always wins.
module counter_disable_delay #(
   parameter int COUNTER_WIDTH = 16
) (
   input logic                    clock,
   input logic                    reset,
   counter_disable_delay_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t                   state_q, state_nxt;
   logic [COUNTER_WIDTH-1:0] counter_q, counter_nxt;
   logic [COUNTER_WIDTH-1:0] latched_delay_q, latched_delay_nxt;
   logic                     done_nxt;

   logic                     delayed_enable_q;
   logic                     stopping_q;
   logic                     stop_done_q;

   // State and registered outputs. Outputs are derived from the next state
   // so they change on the same edge as the state transition.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         counter_q        <= '0;
         latched_delay_q  <= '0;
         delayed_enable_q <= 1'b0;
         stopping_q       <= 1'b0;
         stop_done_q      <= 1'b0;
      end else begin
         state_q          <= state_nxt;
         counter_q        <= counter_nxt;
         latched_delay_q  <= latched_delay_nxt;
         delayed_enable_q <= (state_nxt != IDLE);
         stopping_q       <= (state_nxt == STOPPING);
         stop_done_q      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt         = state_q;
      counter_nxt       = counter_q;
      latched_delay_nxt = latched_delay_q;
      done_nxt          = 1'b0;

      if (bus.force_stop) begin
         // Abort from any state, no completion pulse.
         state_nxt   = IDLE;
         counter_nxt = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.enable) begin
                  state_nxt = ACTIVE;
               end
            end
            ACTIVE: begin
               if (!bus.enable) begin
                  if (bus.delay == '0) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt         = STOPPING;
                     counter_nxt       = bus.delay;
                     latched_delay_nxt = bus.delay;
                  end
               end
            end
            STOPPING: begin
               if (bus.enable) begin
                  // Re-assert wins even on the expiry edge.
                  state_nxt   = ACTIVE;
                  counter_nxt = '0;
               end else if (counter_q <= COUNTER_WIDTH'(1)) begin
                  // Counter was loaded with D at the falling edge, so the
                  // edge that sees 1 is the D-th edge after it.
                  state_nxt   = IDLE;
                  counter_nxt = '0;
                  done_nxt    = 1'b1;
               end else begin
                  counter_nxt = counter_q - COUNTER_WIDTH'(1);
               end
            end
            default: begin
               state_nxt   = IDLE;
               counter_nxt = '0;
            end
         endcase
      end
   end

   assign bus.delayedEnable = delayed_enable_q;
   assign bus.stopping      = stopping_q;
   assign bus.stop_done     = stop_done_q;

endmodule

// File: tb/tb_counter_disable_delay.sv
// tb_counter_disable_delay: directed self-checking bench for
// counter_disable_delay with hand-computed expected outputs.
module tb_counter_disable_delay;

   localparam int W = 16;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   counter_disable_delay_if #(.COUNTER_WIDTH(W)) bus ();

   counter_disable_delay #(.COUNTER_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge; outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic de,
                            input logic st, input logic sd);
      check({tag, ".de"}, 32'(bus.delayedEnable), 32'(de));
      check({tag, ".stopping"}, 32'(bus.stopping), 32'(st));
      check({tag, ".stop_done"}, 32'(bus.stop_done), 32'(sd));
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset          = 1'b0;
      bus.enable     = 1'b0;
      bus.delay      = '0;
      bus.force_stop = 1'b0;

      // Reset state, before any clock edge.
      #2;
      check_out("reset", 1'b0, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b1;

      // Idle stays idle with enable low.
      step();
      check_out("idle", 1'b0, 1'b0, 1'b0);

      // Basic turn-on, then turn-off with delay=4.
      bus.enable = 1'b1;
      step();
      check_out("on", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step();
      check_out("on_hold", 1'b1, 1'b0, 1'b0);
      bus.enable = 1'b0;
      bus.delay  = 16'd4;
      step();                                   // edge N
      check_out("d4_n", 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin         // edges N+1..N+3
         step();
         check_out($sformatf("d4_n%0d", i), 1'b1, 1'b1, 1'b0);
      end
      step();                                   // edge N+4
      check_out("d4_end", 1'b0, 1'b0, 1'b1);
      step();
      check_out("d4_after", 1'b0, 1'b0, 1'b0);

      // delay=0: immediate off with a completion pulse.
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.delay  = 16'd0;
      step();
      check_out("d0", 1'b0, 1'b0, 1'b1);
      step();
      check_out("d0_after", 1'b0, 1'b0, 1'b0);

      // delay=8, re-assert after 4 edges, then full 8-cycle turn-off.
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.delay  = 16'd8;
      for (int i = 0; i < 4; i++) begin         // edges N..N+3
         step();
         check_out($sformatf("d8_cnt%0d", i), 1'b1, 1'b1, 1'b0);
      end
      bus.enable = 1'b1;
      step();                                   // edge N+4: re-assert
      check_out("d8_reassert", 1'b1, 1'b0, 1'b0);
      step();
      check_out("d8_active", 1'b1, 1'b0, 1'b0);
      bus.enable = 1'b0;
      step();                                   // second fall, edge M
      check_out("d8b_m", 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) step();       // edges M+1..M+7
      check_out("d8b_m7", 1'b1, 1'b1, 1'b0);
      step();                                   // edge M+8
      check_out("d8b_end", 1'b0, 1'b0, 1'b1);

      // delay=6, input changes to 2 mid-count: still 6 cycles.
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.delay  = 16'd6;
      step();                                   // edge N
      step();                                   // edge N+1
      bus.delay = 16'd2;
      for (int i = 2; i < 6; i++) begin         // edges N+2..N+5
         step();
         check_out($sformatf("d6_n%0d", i), 1'b1, 1'b1, 1'b0);
      end
      step();                                   // edge N+6
      check_out("d6_end", 1'b0, 1'b0, 1'b1);

      // delay=10, force_stop with enable=1 after 3 edges of counting.
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.delay  = 16'd10;
      for (int i = 0; i < 3; i++) step();
      check_out("fs_pre", 1'b1, 1'b1, 1'b0);
      bus.enable     = 1'b1;
      bus.force_stop = 1'b1;
      step();
      check_out("fs_hit", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      check_out("fs_hold", 1'b0, 1'b0, 1'b0);
      bus.force_stop = 1'b0;
      step();
      check_out("fs_release", 1'b1, 1'b0, 1'b0);

      // Re-assert on the exact expiry edge (delay=2).
      bus.enable = 1'b0;
      bus.delay  = 16'd2;
      step();                                   // edge N
      step();                                   // edge N+1
      bus.enable = 1'b1;
      step();                                   // edge N+2 = expiry
      check_out("expiry_reassert", 1'b1, 1'b0, 1'b0);
      step();
      check_out("expiry_after", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-STOPPING.
      bus.enable = 1'b0;
      bus.delay  = 16'd5;
      step();
      step();
      check_out("rst_pre", 1'b1, 1'b1, 1'b0);
      bus.enable = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check_out("rst_async", 1'b0, 1'b0, 1'b0);
      step();
      step();
      check_out("rst_held", 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      step();
      check_out("rst_release", 1'b1, 1'b0, 1'b0);

      // Maximum delay: 2^16-1 cycles of extension, no wrap.
      bus.enable = 1'b0;
      bus.delay  = 16'hFFFF;
      step();                                   // edge N
      for (int i = 1; i < 65535; i++) step();   // edges N+1..N+65534
      check_out("max_last", 1'b1, 1'b1, 1'b0);
      step();                                   // edge N+65535
      check_out("max_end", 1'b0, 1'b0, 1'b1);
      step();
      check_out("max_after", 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_disable_delay.md
COUNTER_DISABLE_DELAY -- requirements
Module: counter_disable_delay

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16: width of the delay input and the internal down-counter.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of clock.
REQ-004 enable  input  1  level request; 1 = output on, 1->0 = begin delayed turn-off.
REQ-005 delay  input  COUNTER_WIDTH  turn-off delay in clock cycles, unsigned.
REQ-006 force_stop  input  1  synchronous abort; 1 = deassert output at the next edge, no delay.
REQ-007 delayedEnable  output  1  registered, delayed-off version of enable.
REQ-008 stopping  output  1  registered; 1 while a turn-off delay is counting.
REQ-009 stop_done  output  1  registered single-cycle pulse when a delayed turn-off completes.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE (delayedEnable=0), ACTIVE (delayedEnable=1), STOPPING (delayedEnable=1, stopping=1).
REQ-011 IDLE->ACTIVE: at the edge sampling enable=1 and force_stop=0; delayedEnable=1 after that same edge (1-cycle registered latency, no turn-on delay).
REQ-012 ACTIVE, edge samples enable=0, delay!=0: latch delay into latched_delay, load counter=delay, go to STOPPING, stopping=1 after that edge.
REQ-013 ACTIVE, edge samples enable=0, delay==0: go to IDLE, delayedEnable=0 after that edge, stop_done=1 for one cycle.
REQ-014 STOPPING: counter decrements by 1 each edge; delay input changes SHALL be ignored until next entry into STOPPING.
REQ-015 Turn-off timing: with enable sampled low at edge N and latched_delay=D>0, delayedEnable SHALL remain 1 after edges N..N+D-1 and be 0 after edge N+D.
REQ-016 At edge N+D: state->IDLE, stopping=0, stop_done=1 for exactly one cycle, counter=0.
REQ-017 STOPPING, edge samples enable=1 (re-assert): abort the countdown, state->ACTIVE, delayedEnable stays 1 (no glitch), stopping=0, counter cleared, no stop_done.
REQ-018 force_stop=1 sampled in any state: state->IDLE, delayedEnable=0, stopping=0, counter=0 at that edge; stop_done SHALL NOT pulse.
REQ-019 force_stop has priority over enable at the same edge; while force_stop=1, IDLE SHALL NOT exit.
REQ-020 Counter SHALL be COUNTER_WIDTH bits, never wrap: decrement only while STOPPING and counter>0; D=2^COUNTER_WIDTH-1 SHALL give exactly that many cycles of extension.
REQ-021 Enable re-asserting in the same edge that the countdown would expire (edge N+D) SHALL take precedence: state->ACTIVE, delayedEnable=1, no stop_done.
REQ-022 stop_done and stopping SHALL never be 1 in the same cycle; delayedEnable SHALL be 1 whenever stopping=1.

Reset
REQ-023 On reset=0: state=IDLE, delayedEnable=0, stopping=0, stop_done=0, counter=0, latched_delay=0, asynchronously.
REQ-024 Reset asserted mid-STOPPING SHALL drop delayedEnable immediately with no stop_done; after release the block SHALL wait in IDLE for enable sampled high.
REQ-025 Reset release SHALL be honoured synchronously; the first edge after release may already act on enable.

Verification
REQ-026 enable 0->1 at edge 5 -> delayedEnable=1 after edge 5; enable 1->0 at edge 20, delay=4 -> delayedEnable=1 through edge 23, 0 after edge 24, stop_done high cycle after edge 24 only.
REQ-027 delay=0, enable falls at edge 10 -> delayedEnable=0 and stop_done=1 after edge 10, stopping never 1.
REQ-028 delay=8, enable falls at edge 10, re-asserts at edge 14 -> delayedEnable continuously 1, stopping 1 after edges 10-13 then 0, no stop_done; second fall completes 8 cycles later.
REQ-029 delay=6, enable falls at edge 10, delay changed to 2 at edge 12 -> turn-off still at edge 16.
REQ-030 delay=10, enable falls at edge 10, force_stop=1 at edge 13 (and enable=1 same edge) -> delayedEnable=0 after edge 13, no stop_done, stays IDLE while force_stop=1.
REQ-031 reset pulsed low asynchronously mid-STOPPING (between edges) -> all outputs 0 immediately; enable held high after release -> delayedEnable=1 after first edge post-release.
